// File: rtl/alu_arb_if.sv
// Client request/response and ALU-side signal bundle for alu_arb.
// slave: the arbiter's view; master: the clients' and ALU's view.
interface alu_arb_if;
  localparam int unsigned DW  = 8;
  localparam int unsigned OPW = 4;

  logic           req0_valid;
  logic           req0_ready;
  logic [OPW-1:0] req0_op;
  logic [DW-1:0]  req0_a;
  logic [DW-1:0]  req0_b;
  logic           rsp0_valid;
  logic [DW-1:0]  rsp0_data;
  logic           rsp0_err;

  logic           req1_valid;
  logic           req1_ready;
  logic [OPW-1:0] req1_op;
  logic [DW-1:0]  req1_a;
  logic [DW-1:0]  req1_b;
  logic           rsp1_valid;
  logic [DW-1:0]  rsp1_data;
  logic           rsp1_err;

  logic [DW-1:0]  alu_i1;
  logic [DW-1:0]  alu_i2;
  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_o;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_o,
    output req0_ready, rsp0_valid, rsp0_data, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_data, rsp1_err,
    output alu_i1, alu_i2, alu_op
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_o,
    input  req0_ready, rsp0_valid, rsp0_data, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_data, rsp1_err,
    input  alu_i1, alu_i2, alu_op
  );
endinterface

// File: rtl/alu_arb.sv
// Two-client round-robin arbiter/sequencer for the shared 8-bit filter ALU.
// Each op runs IDLE (accept) -> EXEC (drive ALU) -> RESP (one-cycle pulse).
module alu_arb (
  input  logic       clk,
  input  logic       rst,
  alu_arb_if.slave   bus
);
  localparam int unsigned DW  = 8;
  localparam int unsigned OPW = 4;
  localparam logic [OPW-1:0] OP_DIV = OPW'(4);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t         state, state_nx;
  logic           last;
  logic           gnt_r;
  logic [OPW-1:0] op_r;
  logic [DW-1:0]  a_r;
  logic [DW-1:0]  b_r;
  logic [DW-1:0]  res_r;
  logic           err_r;

  logic           gnt_c;
  logic           accept_c;
  logic           div0_c;

  // Contention goes to the port that was not served last.
  always_comb begin
    gnt_c = 1'b0;
    if (bus.req0_valid && bus.req1_valid) gnt_c = ~last;
    else if (bus.req1_valid)              gnt_c = 1'b1;
  end

  assign div0_c = (op_r == OP_DIV) && (b_r == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    accept_c       = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp0_data  = '0;
    bus.rsp0_err   = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.rsp1_data  = '0;
    bus.rsp1_err   = 1'b0;
    bus.alu_op     = '0;
    bus.alu_i1     = '0;
    bus.alu_i2     = '0;
    case (state)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          accept_c       = 1'b1;
          bus.req0_ready = ~gnt_c;
          bus.req1_ready = gnt_c;
          state_nx       = EXEC;
        end
      end
      EXEC: begin
        bus.alu_op = op_r;
        bus.alu_i1 = a_r;
        bus.alu_i2 = b_r;
        state_nx   = RESP;
      end
      RESP: begin
        if (gnt_r) begin
          bus.rsp1_valid = 1'b1;
          bus.rsp1_data  = res_r;
          bus.rsp1_err   = err_r;
        end else begin
          bus.rsp0_valid = 1'b1;
          bus.rsp0_data  = res_r;
          bus.rsp0_err   = err_r;
        end
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Payload capture on accept, result capture in EXEC, fairness pointer in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      last  <= 1'b1;
      gnt_r <= 1'b0;
      op_r  <= '0;
      a_r   <= '0;
      b_r   <= '0;
      res_r <= '0;
      err_r <= 1'b0;
    end else begin
      if (accept_c) begin
        gnt_r <= gnt_c;
        op_r  <= gnt_c ? bus.req1_op : bus.req0_op;
        a_r   <= gnt_c ? bus.req1_a  : bus.req0_a;
        b_r   <= gnt_c ? bus.req1_b  : bus.req0_b;
      end
      if (state == EXEC) begin
        err_r <= div0_c;
        res_r <= div0_c ? '0 : bus.alu_o;
      end
      if (state == RESP) last <= gnt_r;
    end
  end
endmodule

// File: tb/tb_alu_arb.sv
// Scoreboard bench for alu_arb: directed scenarios plus random two-client traffic,
// with an external ALU model and a transaction-level reference.
module tb_alu_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  alu_arb_if bus();

  alu_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External combinational ALU: 1 add, 2 sub, 3 mul, 4 div, 5 and, 6 or, 7 xor.
  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd1: return 8'(a + b);
      4'd2: return 8'(a - b);
      4'd3: return 8'(a * b);
      4'd4: return (b == 8'd0) ? 8'hFF : 8'(a / b);
      4'd5: return a & b;
      4'd6: return a | b;
      4'd7: return a ^ b;
      default: return 8'd0;
    endcase
  endfunction

  assign bus.alu_o = alu_f(bus.alu_op, bus.alu_i1, bus.alu_i2);

  typedef struct {
    int         port;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] data;
    logic       err;
    int         acc;
  } exp_t;

  exp_t sb[$];
  logic last_m = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor/scoreboard: reference arbitration, ALU drive window and response timing.
  always @(negedge clk) begin
    logic       busy, e_r0, e_r1, w;
    logic       e_v0, e_e0, e_v1, e_e1;
    logic [7:0] e_d0, e_d1, e_i1, e_i2;
    logic [3:0] e_op;
    exp_t       e;
    if (cyc >= 1) begin
      busy = (sb.size() > 0);
      e_op = 4'd0; e_i1 = 8'd0; e_i2 = 8'd0;
      if (busy && sb[0].acc + 1 == cyc) begin
        e_op = sb[0].op; e_i1 = sb[0].a; e_i2 = sb[0].b;
      end
      chk("alu_op", 32'(bus.alu_op), 32'(e_op));
      chk("alu_i1", 32'(bus.alu_i1), 32'(e_i1));
      chk("alu_i2", 32'(bus.alu_i2), 32'(e_i2));

      e_v0 = 1'b0; e_d0 = 8'd0; e_e0 = 1'b0;
      e_v1 = 1'b0; e_d1 = 8'd0; e_e1 = 1'b0;
      if (busy && sb[0].acc + 2 == cyc) begin
        e = sb.pop_front();
        if (e.port == 0) begin e_v0 = 1'b1; e_d0 = e.data; e_e0 = e.err; end
        else             begin e_v1 = 1'b1; e_d1 = e.data; e_e1 = e.err; end
        last_m = (e.port == 1);
      end
      chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(e_v0));
      chk("rsp0_data",  32'(bus.rsp0_data),  32'(e_d0));
      chk("rsp0_err",   32'(bus.rsp0_err),   32'(e_e0));
      chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(e_v1));
      chk("rsp1_data",  32'(bus.rsp1_data),  32'(e_d1));
      chk("rsp1_err",   32'(bus.rsp1_err),   32'(e_e1));

      e_r0 = 1'b0; e_r1 = 1'b0; w = 1'b0;
      if (!busy && (bus.req0_valid || bus.req1_valid)) begin
        if (bus.req0_valid && bus.req1_valid) w = (last_m == 1'b0);
        else                                  w = bus.req1_valid;
        e_r0 = ~w; e_r1 = w;
        if (!rst) begin
          e.port = w ? 1 : 0;
          e.op   = w ? bus.req1_op : bus.req0_op;
          e.a    = w ? bus.req1_a  : bus.req0_a;
          e.b    = w ? bus.req1_b  : bus.req0_b;
          e.err  = (e.op == 4'd4) && (e.b == 8'd0);
          e.data = e.err ? 8'd0 : alu_f(e.op, e.a, e.b);
          e.acc  = cyc;
          sb.push_back(e);
        end
      end
      chk("req0_ready", 32'(bus.req0_ready), 32'(e_r0));
      chk("req1_ready", 32'(bus.req1_ready), 32'(e_r1));

      if (rst) begin
        sb.delete();
        last_m = 1'b1;
      end
    end
  end

  task automatic set_req(input int p, input logic v, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  // Present a request, hold it until ready, then scramble the payload.
  task automatic send(input int p, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int   n;
    logic got;
    n = 0;
    set_req(p, 1'b1, op, a, b);
    do begin
      @(negedge clk);
      n++;
      got = (p == 0) ? bus.req0_ready : bus.req1_ready;
    end while (!got && n < 100);
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout port %0d: got no ready expected ready within 100 cycles", p);
    end
    @(posedge clk); #1;
    set_req(p, 1'b0, 4'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_client(input int p, input int n_ops);
    logic [7:0] b;
    for (int i = 0; i < n_ops; i++) begin
      idle($urandom_range(0, 2));
      b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      send(p, 4'($urandom_range(0, 15)), 8'($urandom), b);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000 ns");
    $fatal(1);
  end

  initial begin
    set_req(0, 1'b0, 4'd0, 8'd0, 8'd0);
    set_req(1, 1'b0, 4'd0, 8'd0, 8'd0);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;

    // Single add on port 0, then divide-by-zero and a normal divide on port 1.
    send(0, 4'd1, 8'hF0, 8'h20);
    idle(3);
    send(1, 4'd4, 8'd100, 8'd0);
    send(1, 4'd4, 8'd100, 8'd7);
    idle(4);

    // Continuous contention: grants must alternate starting with port 0.
    fork
      begin for (int i = 0; i < 4; i++) send(0, 4'd2, 8'd5, 8'd3); end
      begin for (int j = 0; j < 4; j++) send(1, 4'd3, 8'd16, 8'd17); end
    join
    idle(4);

    // Reset during EXEC discards the op.
    send(0, 4'd3, 8'd3, 8'd4);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);
    send(1, 4'd6, 8'h0F, 8'hF0);
    idle(4);

    // Unknown op codes.
    send(0, 4'd0, 8'h55, 8'h66);
    send(1, 4'd9, 8'hAA, 8'h01);
    idle(4);

    // Port 1 arrives during port 0's EXEC and must wait.
    fork
      send(0, 4'd1, 8'd200, 8'd100);
      begin idle(1); send(1, 4'd2, 8'd50, 8'd80); end
    join
    idle(4);

    // Random traffic from both clients.
    fork
      rand_client(0, 25);
      rand_client(1, 25);
    join
    idle(6);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
